unpack: RTL and testbench

UNPACK -- requirements
Module: unpack

---
 rtl/unpack.sv | 61 ++++++
 tb/tb_unpack.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/unpack.sv
// Splits each W*D-bit upstream word into D sub-words of W bits, emitted one per
// handshake. LSB- or MSB-first per ORDER. The last sub-word can hand off to the next word with no bubble.
module unpack #(
   parameter int W     = 8,
   parameter int D     = 2,
   parameter int ORDER = 0
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           s_stb,
   input  logic [W*D-1:0] s_dat,
   output logic           s_rdy,
   output logic           m_stb,
   output logic [W-1:0]   m_dat,
   output logic           m_last,
   input  logic           m_rdy
);

   localparam int IW = (D > 1) ? $clog2(D) : 1;
   localparam logic [IW-1:0] LAST = IW'(D - 1);

   typedef enum logic {EMPTY, BUSY} state_t;

   state_t                state;
   logic [IW-1:0]         idx;
   logic [D-1:0][W-1:0]   hold;
   logic [D-1:0][W-1:0]   ordv;
   logic                  at_last;
   logic                  in_xfer;
   logic                  out_xfer;

   // Reorder once so emission always walks ordv[0..D-1] regardless of ORDER.
   for (genvar k = 0; k < D; k++) begin : g_ord
      assign ordv[k] = hold[(ORDER != 0) ? (D - 1 - k) : k];
   end

   assign at_last  = (state == BUSY) && (idx == LAST);
   assign s_rdy    = !rst && ((state == EMPTY) || (at_last && m_rdy));
   assign m_stb    = !rst && (state == BUSY);
   assign m_dat    = ordv[idx];
   assign m_last   = at_last;
   assign in_xfer  = s_stb && s_rdy;
   assign out_xfer = m_stb && m_rdy;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= EMPTY;
         idx   <= '0;
         hold  <= '0;
      end else if (in_xfer) begin
         // Covers both a load from EMPTY and the zero-bubble reload on the last sub-word.
         hold  <= s_dat;
         idx   <= '0;
         state <= BUSY;
      end else if (out_xfer) begin
         if (at_last) state <= EMPTY;
         else         idx   <= idx + 1'b1;
      end
   end

endmodule

// File: tb/tb_unpack.sv
// Self-checking bench for unpack: three configurations (8x2 LSB-first, 8x3 MSB-first,
// 16x1) run against a queue-based model, plus directed literal cases.
module tb_unpack;

   typedef struct {
      logic [15:0] dat;
      logic        last;
   } sw_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  sstb;
   logic [2:0]  mrdy;
   logic [23:0] sdat [3];
   logic        sr0, sr1, sr2, ms0, ms1, ms2, ml0, ml1, ml2;
   logic [7:0]  md0, md1;
   logic [15:0] md2;
   logic [2:0]  srdy, mstb, mlast;
   logic [15:0] mdat [3];

   int vectors = 0;
   int miscompares = 0;
   int accepted = 0;
   int emitted = 0;
   sw_t  mq [3][$];
   logic [2:0] acc;
   logic [2:0] zflag;

   always #5 clk = ~clk;

   unpack #(.W(8),  .D(2), .ORDER(0)) u0 (.clk(clk), .rst(rst), .s_stb(sstb[0]), .s_dat(sdat[0][15:0]),
      .s_rdy(sr0), .m_stb(ms0), .m_dat(md0), .m_last(ml0), .m_rdy(mrdy[0]));
   unpack #(.W(8),  .D(3), .ORDER(1)) u1 (.clk(clk), .rst(rst), .s_stb(sstb[1]), .s_dat(sdat[1]),
      .s_rdy(sr1), .m_stb(ms1), .m_dat(md1), .m_last(ml1), .m_rdy(mrdy[1]));
   unpack #(.W(16), .D(1), .ORDER(0)) u2 (.clk(clk), .rst(rst), .s_stb(sstb[2]), .s_dat(sdat[2][15:0]),
      .s_rdy(sr2), .m_stb(ms2), .m_dat(md2), .m_last(ml2), .m_rdy(mrdy[2]));

   assign srdy  = {sr2, sr1, sr0};
   assign mstb  = {ms2, ms1, ms0};
   assign mlast = {ml2, ml1, ml0};
   assign mdat[0] = {8'h00, md0};
   assign mdat[1] = {8'h00, md1};
   assign mdat[2] = md2;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // A word becomes its sub-words in emission order, last one flagged.
   function automatic void load(int d, logic [23:0] v);
      int  nd, nw, j;
      sw_t e;
      nd = (d == 0) ? 2 : (d == 1) ? 3 : 1;
      nw = (d == 2) ? 16 : 8;
      for (int k = 0; k < nd; k++) begin
         j = (d == 1) ? nd - 1 - k : k;
         e.dat  = 16'((v >> (j * nw)) & ((24'd1 << nw) - 24'd1));
         e.last = (k == nd - 1);
         mq[d].push_back(e);
      end
   endfunction

   // Model: queue holds the remaining sub-words of the held word.
   always @(posedge clk) begin
      for (int d = 0; d < 3; d++) begin
         logic er;
         er = (mq[d].size() == 0) || (mq[d].size() == 1 && mrdy[d]);
         acc[d] = 1'b0;
         if (rst) begin
            mq[d].delete();
            zflag[d] = 1'b1;
         end else begin
            if (mq[d].size() > 0 && mrdy[d]) begin
               if (d == 2 && mq[d][0].last) emitted++;
               void'(mq[d].pop_front());
            end
            if (sstb[d] && er) begin
               load(d, sdat[d]);
               acc[d]   = 1'b1;
               zflag[d] = 1'b0;
               if (d == 2) accepted++;
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         logic ers, ems;
         ers = !rst && ((mq[d].size() == 0) || (mq[d].size() == 1 && mrdy[d]));
         ems = !rst && (mq[d].size() > 0);
         chk($sformatf("s_rdy%0d", d), 32'(srdy[d]), 32'(ers));
         chk($sformatf("m_stb%0d", d), 32'(mstb[d]), 32'(ems));
         if (ems) begin
            chk($sformatf("m_dat%0d", d),  32'(mdat[d]),  32'(mq[d][0].dat));
            chk($sformatf("m_last%0d", d), 32'(mlast[d]), 32'(mq[d][0].last));
         end else if (!rst && zflag[d]) begin
            chk($sformatf("m_dat_rst%0d", d),  32'(mdat[d]),  32'h0);
            chk($sformatf("m_last_rst%0d", d), 32'(mlast[d]), 32'h0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; sstb = '0; mrdy = '0;
      for (int d = 0; d < 3; d++) sdat[d] = '0;
      zflag = '1; acc = '0;
      tick(); tick();
      #1 chk("rst_s_rdy", 32'(sr0), 0);
      chk("rst_m_stb", 32'(ms0), 0);
      rst = 1'b0;
      #1 chk("post_rst_s_rdy", 32'(sr0), 1);
      chk("post_rst_m_stb", 32'(ms0), 0);

      // Single word, LSB first
      sstb[0] = 1; sdat[0] = 24'h00BEEF; mrdy[0] = 1;
      tick(); sstb[0] = 0; sdat[0] = 24'h005555;
      #1 chk("beef_0", 32'(md0), 32'hEF); chk("beef_0_last", 32'(ml0), 0);
      tick();
      #1 chk("beef_1", 32'(md0), 32'hBE); chk("beef_1_last", 32'(ml0), 1);
      tick();
      #1 chk("beef_done", 32'(ms0), 0);

      // Back-to-back words
      sstb[0] = 1; sdat[0] = 24'h001234;
      tick(); sdat[0] = 24'h005678;
      #1 chk("b2b_0", 32'(md0), 32'h34); chk("b2b_0_rdy", 32'(sr0), 0);
      tick();
      #1 chk("b2b_1", 32'(md0), 32'h12); chk("b2b_1_rdy", 32'(sr0), 1);
      tick(); sstb[0] = 0;
      #1 chk("b2b_2", 32'(md0), 32'h78); chk("b2b_2_stb", 32'(ms0), 1); chk("b2b_2_rdy", 32'(sr0), 0);
      tick();
      #1 chk("b2b_3", 32'(md0), 32'h56); chk("b2b_3_rdy", 32'(sr0), 1);
      tick();
      #1 chk("b2b_done", 32'(ms0), 0);

      // MSB first, three sub-words
      sstb[1] = 1; sdat[1] = 24'hA1B2C3; mrdy[1] = 1;
      tick(); sstb[1] = 0;
      #1 chk("msb_0", 32'(md1), 32'hA1); chk("msb_0_last", 32'(ml1), 0);
      tick();
      #1 chk("msb_1", 32'(md1), 32'hB2); chk("msb_1_last", 32'(ml1), 0);
      tick();
      #1 chk("msb_2", 32'(md1), 32'hC3); chk("msb_2_last", 32'(ml1), 1);
      tick(); mrdy[1] = 0;

      // Backpressure
      sstb[0] = 1; sdat[0] = 24'h00BEEF;
      tick(); sstb[0] = 0; mrdy[0] = 0; sdat[0] = 24'h000000;
      for (int i = 0; i < 5; i++) begin
         #1 chk("bp_hold", 32'(md0), 32'hEF); chk("bp_rdy", 32'(sr0), 0);
         tick();
      end
      mrdy[0] = 1;
      #1 chk("bp_resume_0", 32'(md0), 32'hEF);
      tick();
      #1 chk("bp_resume_1", 32'(md0), 32'hBE); chk("bp_resume_last", 32'(ml0), 1);
      tick();

      // Reset while the second sub-word is pending
      sstb[0] = 1; sdat[0] = 24'h00BEEF;
      tick(); sstb[0] = 0;
      #1 chk("mid_0", 32'(md0), 32'hEF);
      tick(); rst = 1;
      #1 chk("mid_rst_stb", 32'(ms0), 0);
      tick(); rst = 0;
      #1 chk("mid_after_rdy", 32'(sr0), 1); chk("mid_after_stb", 32'(ms0), 0);
      chk("mid_after_dat", 32'(md0), 0);
      tick();
      #1 chk("mid_no_ghost", 32'(ms0), 0);

      // Random streams on all three configurations
      for (int c = 0; c < 20000 && accepted < 1000; c++) begin
         tick();
         for (int d = 0; d < 3; d++) begin
            if (!sstb[d] || acc[d]) begin
               sstb[d] = ($urandom_range(0, 9) < 7) && !(d == 2 && accepted >= 1000);
               sdat[d] = 24'($urandom());
            end
            mrdy[d] = 1'($urandom_range(0, 1));
         end
      end
      chk("stream_words", 32'(accepted), 32'd1000);
      sstb = '0; mrdy = '1;
      for (int c = 0; c < 50 && (mq[0].size() + mq[1].size() + mq[2].size()) != 0; c++) tick();
      tick();
      chk("drain_empty", 32'(mq[0].size() + mq[1].size() + mq[2].size()), 0);
      chk("stream_emitted", 32'(emitted), 32'd1000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
